// File: rtl/md_unit_ctrl_pkg.sv
// Shared constants for the multiply/divide unit: md_op codes and sequencer states.
// MADD/MADDU codes are only honoured when MD_UNIT_MADD_EN is defined.
package md_unit_ctrl_pkg;

   localparam int MD_OP_W = 4;

   localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
   localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
   localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
   localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
   localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
   localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
   localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
   localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
   localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_unit_ctrl_arith.sv
// Combinational result generator: 64-bit products, accumulates, quotient/remainder.
// res_wr is low when the op leaves HI/LO untouched (divide by zero, non-calc codes).
module md_unit_ctrl_arith
   import md_unit_ctrl_pkg::*;
(
   input  logic [MD_OP_W-1:0] op,
   input  logic [31:0]        a,
   input  logic [31:0]        b,
   input  logic [31:0]        hi_in,
   input  logic [31:0]        lo_in,
   output logic [31:0]        res_hi,
   output logic [31:0]        res_lo,
   output logic               res_wr
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [63:0] acc;
   logic [31:0] quot_s;
   logic [31:0] rem_s;
   logic [31:0] quot_u;
   logic [31:0] rem_u;

   always_comb begin
      prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      prod_u = {32'd0, a} * {32'd0, b};
      acc    = {hi_in, lo_in};

      quot_s = 32'd0;
      rem_s  = 32'd0;
      quot_u = 32'd0;
      rem_u  = 32'd0;
      if (b != 32'd0) begin
         // Most-negative / -1 does not fit; pin the architectural result explicitly.
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            quot_s = 32'h8000_0000;
            rem_s  = 32'd0;
         end else begin
            quot_s = $signed(a) / $signed(b);
            rem_s  = $signed(a) % $signed(b);
         end
         quot_u = a / b;
         rem_u  = a % b;
      end

      res_hi = 32'd0;
      res_lo = 32'd0;
      res_wr = 1'b0;
      case (op)
         MD_MULT:  begin {res_hi, res_lo} = prod_s;       res_wr = 1'b1; end
         MD_MULTU: begin {res_hi, res_lo} = prod_u;       res_wr = 1'b1; end
         MD_MADD:  begin {res_hi, res_lo} = acc + prod_s; res_wr = 1'b1; end
         MD_MADDU: begin {res_hi, res_lo} = acc + prod_u; res_wr = 1'b1; end
         MD_DIV:   begin res_lo = quot_s; res_hi = rem_s; res_wr = (b != 32'd0); end
         MD_DIVU:  begin res_lo = quot_u; res_hi = rem_u; res_wr = (b != 32'd0); end
         default:  ;
      endcase
   end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multi-cycle mult/div sequencer owning HI/LO; define MD_UNIT_MADD_EN to enable MADD/MADDU.
//   state   | meaning
//   ST_IDLE | busy=0; accepts calc ops and MTHI/MTLO
//   ST_RUN  | busy=1; cnt counts down, commit pending result when it hits 0
module md_unit_ctrl
   import md_unit_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [MD_OP_W-1:0] md_op,
   input  logic [31:0]        A,
   input  logic [31:0]        B,
   output logic               busy,
   output logic               md_stall,
   output logic [31:0]        hi,
   output logic [31:0]        lo
);

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

   md_state_e   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic        pend_wr_q, pend_wr_d;

   logic        madd_op;
   logic        mult_op;
   logic        calc_op;
   logic        idle;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        res_wr;

   md_unit_ctrl_arith u_arith (
      .op     (md_op),
      .a      (A),
      .b      (B),
      .hi_in  (hi_q),
      .lo_in  (lo_q),
      .res_hi (res_hi),
      .res_lo (res_lo),
      .res_wr (res_wr)
   );

   always_comb begin
`ifdef MD_UNIT_MADD_EN
      madd_op = (md_op == MD_MADD) || (md_op == MD_MADDU);
`else
      madd_op = 1'b0;
`endif
      mult_op = (md_op == MD_MULT) || (md_op == MD_MULTU) || madd_op;
      calc_op = mult_op || (md_op == MD_DIV) || (md_op == MD_DIVU);
      idle    = (state_q == ST_IDLE);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;

      if (idle) begin
         if (start && calc_op) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            pend_wr_d = res_wr;
            cnt_d     = mult_op ? MULT_LOAD : DIV_LOAD;
            state_d   = ST_RUN;
         end else if (start && md_op == MD_MTHI) begin
            hi_d = A;
         end else if (start && md_op == MD_MTLO) begin
            lo_d = A;
         end
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end else begin
         if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
         end
         pend_wr_d = 1'b0;
         state_d   = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   assign busy     = (state_q == ST_RUN);
   assign md_stall = busy | (start & calc_op);
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule
